voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphonic scheduler: takes decoded MIDI messages (same stream feeding ParameterControl)
//  and assigns NOTE_ON/NOTE_OFF events to VOICES shared oscillator/envelope slots.
//  Drives per-voice note/velocity/gate plus a one-cycle trigger that starts the voice envelope.
//  Steals the least-recently-allocated voice when all slots are busy.
// PARAMETERS
//  VOICES  8  number of voice slots; power of two, 2..16
//  AGE_W   $clog2(VOICES)  width of per-voice LRU age; derived, do not override
// PORTS
//  clock_50_000_000  in   1         system clock
//  reset_l           in   1         asynchronous, active-low reset
//  message           in   MIDI::message_t  decoded MIDI message
//  message_valid     in   1         message is new this cycle; one message per cycle max
//  voice_idle        in   VOICES    envelope of voice i finished release (level 0)
//  voice_note        out  VOICES x 7  note number per voice
//  voice_velocity    out  VOICES x 7  velocity per voice
//  voice_gate        out  VOICES    key held for voice i
//  voice_trigger     out  VOICES    one-cycle pulse: (re)start envelope of voice i
//  voice_stolen      out  1         one-cycle pulse: last allocation stole a gated voice
// BEHAVIOUR
//  Reset: all outputs 0; all ages set to voice index (voice 0 youngest).
//  Latency: message sampled when message_valid=1; outputs updated on next edge (1 cycle).
//  message_valid=0 or other message types: no state change, no pulses.
//  NOTE_ON, velocity>0, allocation priority (first match wins, ties -> lowest index):
//   1 voice with gate=1 and note==message note (retrigger; velocity updated)
//   2 voice with gate=0 and voice_idle=1
//   3 voice with gate=0 (still releasing) having the largest age
//   4 voice with gate=1 having the largest age -> steal; voice_stolen=1
//  Chosen voice: note/velocity loaded, gate<=1, trigger pulse 1 cycle, age<=0;
//   every other voice whose age < chosen voice's old age increments by 1 (LRU; ages stay
//   a permutation of 0..VOICES-1, never wrap).
//  NOTE_ON with velocity 0 == NOTE_OFF.
//  NOTE_OFF: every voice with gate=1 and matching note -> gate<=0; note/velocity held;
//   ages unchanged; no trigger. No match -> ignored.
//  CONTROL_CHANGE controller ALL_NOTES_OFF (123): all gates <=0 in one cycle.
//  voice_idle sampled the same cycle as the message; voice_idle ignored while gate=1.
//  Exactly one voice_trigger bit high per allocating cycle; zero otherwise.
//  Reset asserted mid-operation: immediate return to reset values, pulses dropped.
// STRUCTURE
//  VOICE package: VOICES default, voice_t {note[6:0], velocity[6:0], gate},
//   ALL_NOTES_OFF constant (or in MIDI package alongside TEMPO..VOLUME).
//  NOTE_ON/NOTE_OFF/CONTROL_CHANGE enums come from MIDI package.
//  Sub-module voice_lru_tracker: holds ages, inputs {touch, touch_index},
//   outputs per-voice age; priority encoders stay in voice_allocator.
// TESTING
//  Reset, NOTE_ON 60 vel 100 -> voice0 note=60 vel=100 gate=1, trigger[0] 1 cycle.
//  NOTE_ON 60,62,64 then NOTE_OFF 62 -> voice1 gate=0, voices 0,2 gated, no trigger.
//  Fill 8 voices notes 60..67, NOTE_ON 70 -> voice0 (oldest) note=70, voice_stolen=1.
//  Voice3 gate=0 idle=0, voice5 gate=0 idle=1, NOTE_ON 72 -> voice5 chosen.
//  NOTE_ON 60 twice (vel 50 then 90) -> same voice, vel=90, trigger twice, no new voice.
//  8 voices gated, CC 123 -> all gates 0 next cycle; NOTE_ON vel 0 == NOTE_OFF; reset mid-stream clears.

Source files
------------

// File: rtl/midi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : MIDI                                                          |
// | Description: Decoded MIDI message types shared by the synth control path.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package MIDI;

    typedef enum logic [2:0] {
        NOTE_OFF         = 3'd0,
        NOTE_ON          = 3'd1,
        POLY_PRESSURE    = 3'd2,
        CONTROL_CHANGE   = 3'd3,
        PROGRAM_CHANGE   = 3'd4,
        CHANNEL_PRESSURE = 3'd5,
        PITCH_BEND       = 3'd6,
        SYSTEM           = 3'd7
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [3:0]    channel;
        logic [6:0]    data1;
        logic [6:0]    data2;
    } message_t;

    localparam logic [6:0] MODULATION = 7'd1;
    localparam logic [6:0] VOLUME     = 7'd7;

endpackage : MIDI
`default_nettype wire

// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : voice_allocator_pkg                                           |
// | Description: Voice slot record, allocator actions and message decoding.    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package voice_allocator_pkg;
    import MIDI::*;

    localparam int         VOICES_DEFAULT = 8;
    localparam logic [6:0] ALL_NOTES_OFF  = 7'd123;

    typedef struct packed {
        logic [6:0] note;
        logic [6:0] velocity;
        logic       gate;
    } voice_t;

    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_ALLOCATE = 2'd1,
        ACT_RELEASE  = 2'd2,
        ACT_ALL_OFF  = 2'd3
    } action_t;

    // A NOTE_ON with zero velocity is treated as a release.
    function automatic action_t decode_action(input logic          valid,
                                              input message_type_t kind,
                                              input logic [6:0]    data1,
                                              input logic [6:0]    data2);
        action_t action;
        action = ACT_NONE;
        if (valid) begin
            case (kind)
                NOTE_ON:        action = (data2 != 7'd0) ? ACT_ALLOCATE : ACT_RELEASE;
                NOTE_OFF:       action = ACT_RELEASE;
                CONTROL_CHANGE: if (data1 == ALL_NOTES_OFF) action = ACT_ALL_OFF;
                default:        action = ACT_NONE;
            endcase
        end
        return action;
    endfunction

endpackage : voice_allocator_pkg
`default_nettype wire

// File: rtl/voice_lru_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : voice_lru_tracker                                             |
// | Description: Per-voice allocation age; touched voice becomes youngest.     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module voice_lru_tracker #(
    parameter int VOICES = 8,
    parameter int AGE_W  = $clog2(VOICES)
) (
    input  logic                           clock_50_000_000,
    input  logic                           reset_l,
    input  logic                           touch,
    input  logic [AGE_W-1:0]               touch_index,
    output logic [VOICES-1:0][AGE_W-1:0]   age
);

    logic [AGE_W-1:0] r_age [VOICES];
    logic [AGE_W-1:0] w_old_age;

    assign w_old_age = r_age[touch_index];

    // Only voices younger than the touched one shift, so ages stay a permutation.
    for (genvar g = 0; g < VOICES; g++) begin : g_age
        always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
            if (!reset_l) begin
                r_age[g] <= AGE_W'(g);
            end else if (touch) begin
                if (touch_index == AGE_W'(g)) begin
                    r_age[g] <= '0;
                end else if (r_age[g] < w_old_age) begin
                    r_age[g] <= r_age[g] + AGE_W'(1);
                end
            end
        end

        assign age[g] = r_age[g];
    end

endmodule : voice_lru_tracker
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : voice_allocator                                               |
// | Description: Assigns NOTE_ON/NOTE_OFF to voice slots with LRU stealing.    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module voice_allocator
    import MIDI::*;
    import voice_allocator_pkg::*;
#(
    parameter int VOICES = VOICES_DEFAULT,
    parameter int AGE_W  = $clog2(VOICES)
) (
    input  logic                        clock_50_000_000,
    input  logic                        reset_l,
    input  message_t                    message,
    input  logic                        message_valid,
    input  logic [VOICES-1:0]           voice_idle,
    output logic [VOICES-1:0][6:0]      voice_note,
    output logic [VOICES-1:0][6:0]      voice_velocity,
    output logic [VOICES-1:0]           voice_gate,
    output logic [VOICES-1:0]           voice_trigger,
    output logic                        voice_stolen
);

    action_t                        w_action;
    logic                           w_allocate;
    logic [VOICES-1:0]              w_gate_vec;
    logic [VOICES-1:0]              w_note_hit;
    logic [VOICES-1:0]              w_held_match;
    logic [VOICES-1:0]              w_free_mask;
    logic [VOICES-1:0][AGE_W-1:0]   w_age;
    logic [AGE_W:0]                 w_pick_retrig;
    logic [AGE_W:0]                 w_pick_free;
    logic [AGE_W:0]                 w_pick_release;
    logic [AGE_W:0]                 w_pick_steal;
    logic [AGE_W-1:0]               w_chosen;
    logic                           w_steal;
    logic                           r_stolen;
    logic                           w_unused_channel;

    // Returns {found, index}; lowest set index wins.
    function automatic logic [AGE_W:0] pick_lowest(input logic [VOICES-1:0] mask);
        logic [AGE_W:0] result;
        result = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (mask[i]) result = {1'b1, AGE_W'(i)};
        end
        return result;
    endfunction

    // Returns {found, index} of the oldest masked voice; ties resolve to lowest index.
    function automatic logic [AGE_W:0] pick_oldest(input logic [VOICES-1:0]            mask,
                                                   input logic [VOICES-1:0][AGE_W-1:0] ages);
        logic [AGE_W:0]   result;
        logic [AGE_W-1:0] best;
        result = '0;
        best   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (mask[i] && (!result[AGE_W] || ages[i] > best)) begin
                result = {1'b1, AGE_W'(i)};
                best   = ages[i];
            end
        end
        return result;
    endfunction

    assign w_unused_channel = ^message.channel;

    assign w_action   = decode_action(message_valid, message.message_type,
                                      message.data1, message.data2);
    assign w_allocate = (w_action == ACT_ALLOCATE);

    assign w_held_match = w_gate_vec & w_note_hit;
    assign w_free_mask  = ~w_gate_vec & voice_idle;

    always_comb begin
        w_pick_retrig  = pick_lowest(w_held_match);
        w_pick_free    = pick_lowest(w_free_mask);
        w_pick_release = pick_oldest(~w_gate_vec, w_age);
        w_pick_steal   = pick_oldest(w_gate_vec, w_age);
        w_chosen       = '0;
        w_steal        = 1'b0;
        if (w_pick_retrig[AGE_W]) begin
            w_chosen = w_pick_retrig[AGE_W-1:0];
        end else if (w_pick_free[AGE_W]) begin
            w_chosen = w_pick_free[AGE_W-1:0];
        end else if (w_pick_release[AGE_W]) begin
            w_chosen = w_pick_release[AGE_W-1:0];
        end else if (w_pick_steal[AGE_W]) begin
            w_chosen = w_pick_steal[AGE_W-1:0];
            w_steal  = 1'b1;
        end
    end

    voice_lru_tracker #(
        .VOICES (VOICES),
        .AGE_W  (AGE_W)
    ) u_lru (
        .clock_50_000_000 (clock_50_000_000),
        .reset_l          (reset_l),
        .touch            (w_allocate),
        .touch_index      (w_chosen),
        .age              (w_age)
    );

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        voice_t r_state;
        logic   r_trigger;
        logic   w_pick;
        logic   w_release;

        assign w_pick    = w_allocate && (w_chosen == AGE_W'(g));
        assign w_release = (w_action == ACT_ALL_OFF) ||
                           ((w_action == ACT_RELEASE) && w_held_match[g]);

        always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
            if (!reset_l) begin
                r_state   <= '0;
                r_trigger <= 1'b0;
            end else begin
                r_trigger <= w_pick;
                if (w_pick) begin
                    r_state <= '{note: message.data1, velocity: message.data2, gate: 1'b1};
                end else if (w_release) begin
                    r_state.gate <= 1'b0;
                end
            end
        end

        assign w_gate_vec[g]     = r_state.gate;
        assign w_note_hit[g]     = (r_state.note == message.data1);
        assign voice_note[g]     = r_state.note;
        assign voice_velocity[g] = r_state.velocity;
        assign voice_gate[g]     = r_state.gate;
        assign voice_trigger[g]  = r_trigger;
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            r_stolen <= 1'b0;
        end else begin
            r_stolen <= w_allocate && w_steal;
        end
    end

    assign voice_stolen = r_stolen;

endmodule : voice_allocator
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_voice_allocator                                            |
// | Description: Directed vector bench for voice_allocator (8 voices).         |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_voice_allocator;
    import MIDI::*;

    typedef struct {
        logic          rst;
        logic          valid;
        message_type_t kind;
        logic [6:0]    d1;
        logic [6:0]    d2;
        logic [7:0]    idle;
        logic [7:0]    gate;
        logic [7:0]    trig;
        logic          stolen;
        int            vi;
        logic [6:0]    note;
        logic [6:0]    vel;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_l = 1'b0;
    message_t        message = '0;
    logic            message_valid = 1'b0;
    logic [7:0]      voice_idle = 8'hFF;
    logic [7:0][6:0] voice_note;
    logic [7:0][6:0] voice_velocity;
    logic [7:0]      voice_gate;
    logic [7:0]      voice_trigger;
    logic            voice_stolen;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    voice_allocator #(.VOICES(8)) dut (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .message          (message),
        .message_valid    (message_valid),
        .voice_idle       (voice_idle),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_gate       (voice_gate),
        .voice_trigger    (voice_trigger),
        .voice_stolen     (voice_stolen)
    );

    function automatic vec_t mk(input logic valid, input message_type_t kind,
                                input int d1, input int d2, input logic [7:0] idle,
                                input logic [7:0] gate, input logic [7:0] trig,
                                input logic stolen, input int vi, input int note, input int vel);
        vec_t v;
        v.rst    = 1'b0;
        v.valid  = valid;
        v.kind   = kind;
        v.d1     = 7'(d1);
        v.d2     = 7'(d2);
        v.idle   = idle;
        v.gate   = gate;
        v.trig   = trig;
        v.stolen = stolen;
        v.vi     = vi;
        v.note   = 7'(note);
        v.vel    = 7'(vel);
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v     = mk(1'b0, NOTE_OFF, 0, 0, 8'hFF, 8'h00, 8'h00, 1'b0, 0, 0, 0);
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if (v.rst) begin
            reset_l       = 1'b0;
            message_valid = 1'b0;
            #2;
        end else begin
            message_valid = v.valid;
            message       = '{message_type: v.kind, channel: 4'd0, data1: v.d1, data2: v.d2};
            voice_idle    = v.idle;
            @(posedge clk);
            #1;
        end
        check("gate",    idx, 32'(voice_gate),    32'(v.gate));
        check("trigger", idx, 32'(voice_trigger), 32'(v.trig));
        check("stolen",  idx, 32'(voice_stolen),  32'(v.stolen));
        if (v.vi >= 0) begin
            check("note",     idx, 32'(voice_note[v.vi]),     32'(v.note));
            check("velocity", idx, 32'(voice_velocity[v.vi]), 32'(v.vel));
        end
        if (v.rst) reset_l = 1'b1;
    endtask

    initial begin
        // Basic allocation, release, velocity-0 release, retrigger, ignored messages.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(1, NOTE_ON,        60, 100, 8'hFF, 8'h01, 8'h01, 0,  0, 60, 100));
        tbl.push_back(mk(0, NOTE_ON,         0,   0, 8'hFF, 8'h01, 8'h00, 0,  0, 60, 100));
        tbl.push_back(mk(1, NOTE_ON,        62,  80, 8'hFF, 8'h03, 8'h02, 0,  1, 62,  80));
        tbl.push_back(mk(1, NOTE_ON,        64,  70, 8'hFF, 8'h07, 8'h04, 0,  2, 64,  70));
        tbl.push_back(mk(1, NOTE_OFF,       62,   0, 8'hFF, 8'h05, 8'h00, 0,  1, 62,  80));
        tbl.push_back(mk(1, NOTE_ON,        64,   0, 8'hFF, 8'h01, 8'h00, 0,  2, 64,  70));
        tbl.push_back(mk(1, NOTE_ON,        60,  50, 8'hFF, 8'h01, 8'h01, 0,  0, 60,  50));
        tbl.push_back(mk(1, NOTE_ON,        60,  90, 8'hFF, 8'h01, 8'h01, 0,  0, 60,  90));
        tbl.push_back(mk(1, CONTROL_CHANGE,  7, 100, 8'hFF, 8'h01, 8'h00, 0,  0, 60,  90));
        tbl.push_back(mk(0, NOTE_ON,        65, 100, 8'hFF, 8'h01, 8'h00, 0, -1,  0,   0));
        tbl.push_back(mk(1, NOTE_OFF,       99,   0, 8'hFF, 8'h01, 8'h00, 0, -1,  0,   0));
        // Fill all voices, then steal, then release-priority cases.
        tbl.push_back(mk_rst());
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(1, NOTE_ON, 60 + k, 100, 8'hFF, 8'((1 << (k + 1)) - 1),
                             8'(1 << k), 0, k, 60 + k, 100));
        end
        tbl.push_back(mk(1, NOTE_ON,        70,  33, 8'hFF, 8'hFF, 8'h01, 1,  0, 70,  33));
        tbl.push_back(mk(0, NOTE_ON,         0,   0, 8'hFF, 8'hFF, 8'h00, 0,  0, 70,  33));
        tbl.push_back(mk(1, NOTE_ON,        71,  44, 8'hFF, 8'hFF, 8'h02, 1,  1, 71,  44));
        tbl.push_back(mk(1, NOTE_OFF,       63,   0, 8'hFF, 8'hF7, 8'h00, 0,  3, 63, 100));
        tbl.push_back(mk(1, NOTE_OFF,       65,   0, 8'hFF, 8'hD7, 8'h00, 0,  5, 65, 100));
        tbl.push_back(mk(1, NOTE_ON,        72,  55, 8'hF7, 8'hF7, 8'h20, 0,  5, 72,  55));
        tbl.push_back(mk(1, NOTE_OFF,       71,   0, 8'hFF, 8'hF5, 8'h00, 0,  1, 71,  44));
        tbl.push_back(mk(1, NOTE_ON,        73,  66, 8'h00, 8'hFD, 8'h08, 0,  3, 73,  66));
        tbl.push_back(mk(1, CONTROL_CHANGE,123,   0, 8'hFF, 8'h00, 8'h00, 0,  3, 73,  66));
        tbl.push_back(mk(1, NOTE_ON,        74,  20, 8'hFF, 8'h01, 8'h01, 0,  0, 74,  20));
        // Mid-stream reset restores the initial age order (voice 7 oldest).
        tbl.push_back(mk_rst());
        tbl.push_back(mk(1, NOTE_ON,        80,  10, 8'hFF, 8'h01, 8'h01, 0,  0, 80,  10));
        tbl.push_back(mk(1, NOTE_ON,        81,  11, 8'h00, 8'h81, 8'h80, 0,  7, 81,  11));
        tbl.push_back(mk(1, NOTE_OFF,       99,   0, 8'hFF, 8'h81, 8'h00, 0, -1,  0,   0));

        repeat (2) @(negedge clk);
        reset_l = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k], k);

        // Asynchronous reset while a trigger pulse is high drops the pulse at once.
        @(negedge clk);
        message_valid = 1'b1;
        message       = '{message_type: NOTE_ON, channel: 4'd0, data1: 7'd90, data2: 7'd5};
        voice_idle    = 8'hFF;
        @(posedge clk);
        #1;
        message_valid = 1'b0;
        check("pre-reset trigger", 100, 32'(voice_trigger), 32'h02);
        check("pre-reset note",    100, 32'(voice_note[1]), 32'd90);
        #1;
        reset_l = 1'b0;
        #1;
        check("reset trigger", 101, 32'(voice_trigger), 32'h00);
        check("reset gate",    101, 32'(voice_gate),    32'h00);
        check("reset note",    101, 32'(voice_note[1]), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset idle trigger", 102, 32'(voice_trigger), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_voice_allocator
`default_nettype wire
